// File: rtl/key_debounce.sv
// key_debounce: eight-key piano contact debouncer.
//
// Each raw contact passes through a two-flop synchronizer, then an
// independent four-state FSM (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT). The FSM
// has its own counter and accepts a level change only after DEBOUNCE_CYCLES
// consecutive stable synchronized samples. All outputs are registered.
//
// Build option: define KEY_ACTIVE_LOW_EN for active-low contacts (raw 0 =
// pressed, synchronizer resets to 1). Default build: raw 1 = pressed,
// synchronizer resets to 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   t0..t7       raw asynchronous key contacts (ti = key i)
//   chord[7:0]   debounced key states, 1 = pressed
//   chord_valid  one-cycle pulse whenever chord changes
//   key_press    one-cycle pulse per key on accepted press
//   key_release  one-cycle pulse per key on accepted release
//   key_count    popcount(chord), 0..8
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       t0,
  input  logic       t1,
  input  logic       t2,
  input  logic       t3,
  input  logic       t4,
  input  logic       t5,
  input  logic       t6,
  input  logic       t7,
  output logic [7:0] chord,
  output logic       chord_valid,
  output logic [7:0] key_press,
  output logic [7:0] key_release,
  output logic [3:0] key_count
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_ACTIVE_LOW_EN
  localparam logic [7:0] SYNC_RST = '1;
  localparam logic [7:0] INV      = '1;
`else
  localparam logic [7:0] SYNC_RST = '0;
  localparam logic [7:0] INV      = '0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic [7:0]    raw;
  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    synced;
  state_t        state [8];
  logic [CW-1:0] cnt   [8];
  logic [7:0]    acc_press;
  logic [7:0]    acc_rel;
  logic [7:0]    chord_next;
  logic [3:0]    count_next;

  assign raw = {t7, t6, t5, t4, t3, t2, t1, t0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Synchronized level in "pressed = 1" terms regardless of contact polarity.
  assign synced = sync2 ^ INV;

  // Accepted events are decoded ahead of the register stage so chord,
  // key_count and the pulses all update on the same edge as the FSM transition.
  always_comb begin
    acc_press  = '0;
    acc_rel    = '0;
    count_next = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      acc_press[i] = (state[i] == PRESS_WAIT) && synced[i] && (cnt[i] == TERM);
      acc_rel[i]   = (state[i] == RELEASE_WAIT) && !synced[i] && (cnt[i] == TERM);
    end
    chord_next = (chord | acc_press) & ~acc_rel;
    for (int unsigned i = 0; i < 8; i++) begin
      count_next = count_next + 4'(chord_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      chord       <= '0;
      chord_valid <= 1'b0;
      key_press   <= '0;
      key_release <= '0;
      key_count   <= '0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        case (state[i])
          IDLE: begin
            if (synced[i]) begin
              state[i] <= PRESS_WAIT;
              cnt[i]   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!synced[i]) begin
              state[i] <= IDLE;
            end else if (cnt[i] == TERM) begin
              state[i] <= HELD;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          HELD: begin
            if (!synced[i]) begin
              state[i] <= RELEASE_WAIT;
              cnt[i]   <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (synced[i]) begin
              state[i] <= HELD;
            end else if (cnt[i] == TERM) begin
              state[i] <= IDLE;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
      chord       <= chord_next;
      key_press   <= acc_press;
      key_release <= acc_rel;
      chord_valid <= |{acc_press, acc_rel};
      key_count   <= count_next;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce with DEBOUNCE_CYCLES = 4. Stimulus is written in
// logical "pressed = 1" terms and converted to raw contact levels, so the same
// vectors exercise the KEY_ACTIVE_LOW_EN build.
module tb_key_debounce;

  localparam int unsigned N = 4;

`ifdef KEY_ACTIVE_LOW_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  typedef struct packed {
    logic [7:0] chord;
    logic [7:0] press;
    logic [7:0] rel;
    logic       cv;
    logic [3:0] cnt;
  } exp_t;

  typedef struct {
    logic [7:0] keys;
    exp_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] raw;
  logic [7:0] chord;
  logic       chord_valid;
  logic [7:0] key_press;
  logic [7:0] key_release;
  logic [3:0] key_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned row_id   = 0;

  vec_t tbl [$];
  exp_t sb  [$];

  always #5 clk = ~clk;

  key_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .t0          (raw[0]),
    .t1          (raw[1]),
    .t2          (raw[2]),
    .t3          (raw[3]),
    .t4          (raw[4]),
    .t5          (raw[5]),
    .t6          (raw[6]),
    .t7          (raw[7]),
    .chord       (chord),
    .chord_valid (chord_valid),
    .key_press   (key_press),
    .key_release (key_release),
    .key_count   (key_count)
  );

  task automatic check(input string name, input exp_t e);
    exp_t a;
    a = '{chord: chord, press: key_press, rel: key_release, cv: chord_valid, cnt: key_count};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got chord=%h press=%h rel=%h valid=%b count=%0d, want chord=%h press=%h rel=%h valid=%b count=%0d",
               name, a.chord, a.press, a.rel, a.cv, a.cnt, e.chord, e.press, e.rel, e.cv, e.cnt);
    end
  endtask

  // Append n identical rows: logical key levels plus expected outputs after the edge.
  task automatic add(input int n, input logic [7:0] keys, input logic [7:0] ch,
                     input logic [7:0] pr, input logic [7:0] rl, input logic cv,
                     input logic [3:0] ct);
    vec_t v;
    v.keys = keys;
    v.exp  = '{chord: ch, press: pr, rel: rl, cv: cv, cnt: ct};
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  // Drive each row at the falling edge, push its expectation, compare after the rising edge.
  task automatic run_rows();
    vec_t v;
    exp_t e;
    while (tbl.size() > 0) begin
      v = tbl.pop_front();
      @(negedge clk);
      raw = v.keys ^ INV;
      sb.push_back(v.exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("row%0d", row_id), e);
      row_id++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    raw = INV;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", '0);
    rst = 1'b0;

    // Idle out of reset: no spurious event.
    add(2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    // Single press of t2, accepted on edge 6.
    add(6, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    add(1, 8'h04, 8'h04, 8'h04, 8'h00, 1'b1, 4'd1);
    add(3, 8'h04, 8'h04, 8'h00, 8'h00, 1'b0, 4'd1);
    // t2 drops for 3 samples: no release.
    add(3, 8'h00, 8'h04, 8'h00, 8'h00, 1'b0, 4'd1);
    add(6, 8'h04, 8'h04, 8'h00, 8'h00, 1'b0, 4'd1);
    // Real release of t2.
    add(6, 8'h00, 8'h04, 8'h00, 8'h00, 1'b0, 4'd1);
    add(1, 8'h00, 8'h00, 8'h00, 8'h04, 1'b1, 4'd0);
    add(2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    // t5 glitch of 2 samples: nothing.
    add(2, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    add(8, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    // t0, t3, t7 together: one chord_valid pulse.
    add(6, 8'h89, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    add(1, 8'h89, 8'h89, 8'h89, 8'h00, 1'b1, 4'd3);
    add(3, 8'h89, 8'h89, 8'h00, 8'h00, 1'b0, 4'd3);
    add(6, 8'h00, 8'h89, 8'h00, 8'h00, 1'b0, 4'd3);
    add(1, 8'h00, 8'h00, 8'h00, 8'h89, 1'b1, 4'd0);
    add(2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    // t4 press (single key on the upper half, also the active-low scenario key).
    add(6, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    add(1, 8'h10, 8'h10, 8'h10, 8'h00, 1'b1, 4'd1);
    add(6, 8'h00, 8'h10, 8'h00, 8'h00, 1'b0, 4'd1);
    add(1, 8'h00, 8'h00, 8'h00, 8'h10, 1'b1, 4'd0);
    // t1 accepted before the reset pulse.
    add(6, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    add(1, 8'h02, 8'h02, 8'h02, 8'h00, 1'b1, 4'd1);
    add(2, 8'h02, 8'h02, 8'h00, 8'h00, 1'b0, 4'd1);
    run_rows();

    // One-cycle reset with t1 still held: state drops at once, no release pulse.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_async_drop", '0);
    @(posedge clk);
    #1;
    check("reset_held", '0);
    rst = 1'b0;

    // t1 re-accepted 6 edges after the first post-reset sampling edge.
    add(6, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    add(1, 8'h02, 8'h02, 8'h02, 8'h00, 1'b1, 4'd1);
    add(2, 8'h02, 8'h02, 8'h00, 8'h00, 1'b0, 4'd1);
    run_rows();

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of consecutive stable synchronized samples required to accept a level change (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, meaning an asynchronous, active-high reset.
REQ-004 SHALL have ports t0..t7, input, 1 bit each, meaning the raw asynchronous piano key contacts; ti is key i.
REQ-005 SHALL have port chord, output, 8 bits, meaning the debounced key states, bit i = key i, 1 = pressed; it feeds the synthesizer chord input.
REQ-006 SHALL have port chord_valid, output, 1 bit, meaning a one-cycle pulse whenever chord changes.
REQ-007 SHALL have port key_press, output, 8 bits, meaning a one-cycle pulse per key on accepted press.
REQ-008 SHALL have port key_release, output, 8 bits, meaning a one-cycle pulse per key on accepted release.
REQ-009 SHALL have port key_count, output, 4 bits, meaning the number of set bits in chord (0..8).

Function
REQ-010 SHALL pass each ti through a two-flop synchronizer before any other use.
REQ-011 SHALL implement one independent four-state FSM per key: IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-012 SHALL give each key FSM its own counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-013 In IDLE with synced=1, the FSM SHALL go to PRESS_WAIT with counter=0; otherwise it SHALL stay in IDLE.
REQ-014 In PRESS_WAIT with synced=0, the FSM SHALL return to IDLE with no event.
REQ-015 In PRESS_WAIT, when counter=DEBOUNCE_CYCLES-1 with synced=1, the FSM SHALL go to HELD, set chord[i]=1 and pulse key_press[i].
REQ-016 In PRESS_WAIT with synced=1 before terminal count, the counter SHALL increment by one.
REQ-017 In HELD with synced=0, the FSM SHALL go to RELEASE_WAIT with counter=0.
REQ-018 In RELEASE_WAIT with synced=1, the FSM SHALL return to HELD with no event.
REQ-019 In RELEASE_WAIT at terminal count with synced=0, the FSM SHALL go to IDLE, clear chord[i] and pulse key_release[i].
REQ-020 All outputs SHALL be registered; a settled level change SHALL appear on the (DEBOUNCE_CYCLES+2)th rising edge after the edge that first samples it.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no output change, and a later stable level SHALL restart the count from 0.
REQ-022 Simultaneous accepted events on several keys SHALL update all chord bits on the same edge with a single one-cycle chord_valid pulse.
REQ-023 key_count SHALL update on the same edge as chord and always equal popcount(chord).
REQ-024 chord_valid SHALL be high exactly when any key_press or key_release bit is high.

Reset
REQ-025 While rst=1, all FSMs SHALL be IDLE, counters 0, synchronizer flops at the inactive key level, and chord, chord_valid, key_press, key_release and key_count all 0.
REQ-026 Reset asserted mid-count or while keys are held SHALL drop state immediately with no release pulses.
REQ-027 A key still held after reset release SHALL be re-accepted as a new press after the normal latency.

Configuration
REQ-028 SHALL support macro KEY_ACTIVE_LOW_EN.
REQ-029 With KEY_ACTIVE_LOW_EN defined, raw ti=0 SHALL mean pressed: inputs are inverted before the FSMs, and the synchronizer reset value is 1.
REQ-030 Without KEY_ACTIVE_LOW_EN, raw ti=1 SHALL mean pressed and the synchronizer reset value is 0.

Verification (DEBOUNCE_CYCLES=4, active-high build unless stated)
REQ-031 Bench SHALL cover: t2 rises before edge 0 and stays high -> on edge 6, chord=8'h04, key_press=8'h04, chord_valid=1, key_count=1; all pulses low from edge 7.
REQ-032 Bench SHALL cover: t5 high for 2 samples then low -> chord remains 8'h00; no key_press, key_release or chord_valid pulse.
REQ-033 Bench SHALL cover: t0, t7 and t3 rise on the same cycle -> one chord_valid pulse, chord=8'h89, key_count=3.
REQ-034 Bench SHALL cover: t2 held and accepted, then dropped low for 3 samples and back high -> no key_release; chord stays 8'h04.
REQ-035 Bench SHALL cover: t1 accepted, rst pulsed for 1 cycle with t1 still high -> chord=0 immediately with no key_release; chord=8'h02 again 6 edges after the first post-reset sampling edge.
REQ-036 Bench SHALL cover: KEY_ACTIVE_LOW_EN build with all inputs idle high out of reset, then t4 driven low -> chord=8'h10 on edge 6, with no event at reset release.
